gate_check_seq: RTL and testbench
=================================

# gate_check_seq

Synchronous sequencer that exercises a 2-input gate network (e.g. the NOR-built OR) as its device under test. On `start` it drives the four input combinations 00, 01, 10, 11 in order, waits a programmable settle time after each, samples the DUT output and compares it against a parameterised expected truth table. It reports per-vector failures, an error count and a pass flag, replacing hand-written `$display` truth-table benches with a self-checking lab harness.

## Interface
Parameters:
- `EXP_TT`, 4'b1110: expected output per vector; bit i is the expected `dut_y` for vector i, where {a,b} = i. The default is OR.
- `SETTLE`, 1: cycles to wait after applying a vector before sampling. Legal range is 1..15.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: begin a run; sampled only in IDLE or DONE.
- `dut_y`, in, 1: output of the gate network under test.
- `t_a`, out, 1: DUT input a; equals idx[1].
- `t_b`, out, 1: DUT input b; equals idx[0].
- `busy`, out, 1: high while a run is in progress (WAIT/CHECK).
- `done`, out, 1: high while in DONE; results are valid.
- `pass`, out, 1: `done` && (`err_count` == 0).
- `err_count`, out, 3: number of mismatching vectors, 0..4.
- `fail_mask`, out, 4: bit i set if vector i mismatched.

## Operation
- State variables:
  - `state` ∈ {IDLE, WAIT, CHECK, DONE}.
  - `idx` (2 bits) selects the current vector.
  - `wcnt` (4 bits) is the settle counter.
- IDLE:
  - Outputs are at reset values.
  - `start`=1 → WAIT, with idx=0, wcnt=SETTLE-1, fail_mask=0, err_count=0.
- WAIT:
  - `t_a`/`t_b` drive idx.
  - If wcnt≠0, decrement wcnt.
  - If wcnt=0 → CHECK.
- CHECK: compare `dut_y` against EXP_TT[idx].
  - On mismatch, set fail_mask[idx] and increment err_count.
  - If idx=3 → DONE.
  - Otherwise idx←idx+1, wcnt←SETTLE-1, → WAIT.
- DONE:
  - `done`=1; results and `t_a`/`t_b` (=11) are held.
  - `start`=1 → restart exactly as from IDLE (counters cleared in the same edge).
  - `start`=0 → remain in DONE indefinitely.
- `start` is ignored in WAIT and CHECK; a run cannot be retriggered or extended.
- Arithmetic:
  - err_count never exceeds 4 and never wraps.
  - idx does not wrap inside a run; the transition out of idx=3 goes to DONE.
- Comparison uses `dut_y` as sampled at the CHECK edge only; glitches during WAIT are not observed.

## Timing
- Reset values (all outputs, forced on the first rising edge with `rst`=1):
  - state=IDLE
  - t_a=0, t_b=0
  - busy=0, done=0, pass=0
  - err_count=0, fail_mask=0
- Reset has priority over `start` and over every state transition.
- Reset asserted mid-run aborts the run; partial results are discarded.
- Per-vector cost is SETTLE+1 cycles: SETTLE in WAIT, 1 in CHECK.
- Latency: with `start` sampled at edge E, `done` rises after edge E+4·(SETTLE+1). For SETTLE=1 that is E+8.
- `busy` rises after edge E and falls in the same edge that `done` rises; `busy` and `done` are never both high.
- New `t_a`/`t_b` appear after the CHECK edge of the previous vector, so the DUT has at least SETTLE full cycles before sampling.
- `pass`, `err_count` and `fail_mask` are stable for the whole time `done`=1, and are updated only at CHECK edges.

## Test plan
- **Correct OR network**: NOR-built OR as DUT, EXP_TT=1110, SETTLE=1, pulse start.
  - t_a/t_b step 00→01→10→11, two cycles each.
  - done after 8 edges; pass=1, err_count=0, fail_mask=0000.
- **Wrong gate**: DUT is a bare NOR, EXP_TT=1110.
  - done with pass=0, err_count=4, fail_mask=1111.
- **Single fault**: DUT is an AND, EXP_TT=1110.
  - fail_mask=0110, err_count=2, pass=0.
- **Settle length**: SETTLE=3, correct DUT.
  - done exactly 16 edges after start is sampled.
  - start pulsed again during WAIT has no effect on idx or timing.
- **Reset mid-run**: assert rst during WAIT of vector 2.
  - Next edge: all outputs at reset values, state IDLE.
  - A subsequent start reruns cleanly from vector 0 with fresh results.
- **Restart from DONE**:
  - Hold start=1 after a failing run: results clear in the same edge and a new run begins.
  - Swap to a correct DUT: pass=1 at the second done.

Source files
------------

// File: rtl/gate_check_seq.sv
// Self-checking truth-table sequencer for a 2-input gate network: drives
// {a,b} = 00, 01, 10, 11, waits SETTLE cycles per vector, then compares dut_y to EXP_TT.
module gate_check_seq #(
  parameter logic [3:0]  EXP_TT = 4'b1110,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       t_a,
  output logic       t_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  // The settle counter reloads to SETTLE-1, so WAIT lasts exactly SETTLE cycles.
  localparam logic [3:0] WCNT_RELOAD = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [2:0] err_count_q, err_count_d;
  logic [3:0] fail_mask_q, fail_mask_d;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // values from before the edge; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      wcnt_q      <= 4'd0;
      err_count_q <= 3'd0;
      fail_mask_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      err_count_q <= err_count_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  // NOTE: every next-state signal is defaulted to its current value first, so
  // no path through the case statement leaves a signal unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    err_count_d = err_count_q;
    fail_mask_d = fail_mask_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_WAIT;
          idx_d       = 2'd0;
          wcnt_d      = WCNT_RELOAD;
          err_count_d = 3'd0;
          fail_mask_d = 4'd0;
        end
      end

      S_WAIT: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (dut_y != EXP_TT[idx_q]) begin
          fail_mask_d[idx_q] = 1'b1;
          if (err_count_q != 3'd4) begin
            err_count_d = err_count_q + 3'd1;
          end
        end
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          wcnt_d  = WCNT_RELOAD;
          state_d = S_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // idx is zero whenever IDLE is reachable, and holds 3 in DONE, so the DUT
  // inputs come straight from it.
  assign t_a       = idx_q[1];
  assign t_b       = idx_q[0];
  assign busy      = (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_count_q == 3'd0);
  assign err_count = err_count_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_check_seq.sv
// Directed bench for gate_check_seq: two instances (SETTLE=1 and SETTLE=3)
// driving a selectable gate network (NOR-built OR, bare NOR, AND).
module tb_gate_check_seq;

  logic clk = 1'b0;
  logic rst;
  logic start1, start3;
  int   gate_sel;
  bit   use3;

  logic       y1, ta1, tb1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] mask1;
  logic       y3, ta3, tb3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [3:0] mask3;

  logic       o_ta, o_tb, o_busy, o_done, o_pass;
  logic [2:0] o_err;
  logic [3:0] o_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic gate_fn(input int sel, input logic a, input logic b);
    logic n;
    n = ~(a | b);
    case (sel)
      0:       return ~(n | n);
      1:       return n;
      default: return a & b;
    endcase
  endfunction

  assign y1 = gate_fn(gate_sel, ta1, tb1);
  assign y3 = gate_fn(gate_sel, ta3, tb3);

  gate_check_seq #(.EXP_TT(4'b1110), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .dut_y(y1),
    .t_a(ta1), .t_b(tb1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1)
  );

  gate_check_seq #(.EXP_TT(4'b1110), .SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start3), .dut_y(y3),
    .t_a(ta3), .t_b(tb3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_mask(mask3)
  );

  assign o_ta   = use3 ? ta3   : ta1;
  assign o_tb   = use3 ? tb3   : tb1;
  assign o_busy = use3 ? busy3 : busy1;
  assign o_done = use3 ? done3 : done1;
  assign o_pass = use3 ? pass3 : pass1;
  assign o_err  = use3 ? err3  : err1;
  assign o_mask = use3 ? mask3 : mask1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (use3) start3 = v;
    else      start1 = v;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_t"},    {6'd0, o_ta, o_tb}, 8'd0);
    check({tag, "_busy"}, o_busy, 8'd0);
    check({tag, "_done"}, o_done, 8'd0);
    check({tag, "_pass"}, o_pass, 8'd0);
    check({tag, "_err"},  o_err,  8'd0);
    check({tag, "_mask"}, o_mask, 8'd0);
  endtask

  // One full run on the selected instance; start is high for one edge (E).
  task automatic run(input int settle, input logic [2:0] e_err, input logic [3:0] e_mask,
                     input bit repulse, input string tag);
    int k;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    check({tag, "_start_busy"}, o_busy, 8'd1);
    check({tag, "_start_done"}, o_done, 8'd0);
    check({tag, "_start_err"},  o_err,  8'd0);
    check({tag, "_start_mask"}, o_mask, 8'd0);
    k = 0;
    while (!o_done && k < 64) begin
      check({tag, "_vec"},     {6'd0, o_ta, o_tb}, 8'(k / (settle + 1)));
      check({tag, "_busy_on"}, o_busy, 8'd1);
      set_start(repulse && k == 1);
      tick();
      k++;
    end
    set_start(1'b0);
    check({tag, "_latency"}, 8'(k), 8'(4 * (settle + 1)));
    check({tag, "_done"},    o_done, 8'd1);
    check({tag, "_busy_off"}, o_busy, 8'd0);
    check({tag, "_pass"},    o_pass, 8'(e_err == 3'd0));
    check({tag, "_err"},     o_err,  8'(e_err));
    check({tag, "_mask"},    o_mask, 8'(e_mask));
    check({tag, "_t11"},     {6'd0, o_ta, o_tb}, 8'd3);
    repeat (3) tick();
    check({tag, "_hold_done"}, o_done, 8'd1);
    check({tag, "_hold_err"},  o_err,  8'(e_err));
    check({tag, "_hold_mask"}, o_mask, 8'(e_mask));
  endtask

  initial begin
    rst      = 1'b1;
    start1   = 1'b0;
    start3   = 1'b0;
    gate_sel = 0;
    use3     = 1'b0;
    repeat (2) tick();
    check_reset("rst_s1");
    use3 = 1'b1;
    check_reset("rst_s3");
    use3 = 1'b0;
    rst  = 1'b0;
    tick();
    check_reset("idle_s1");

    // Correct NOR-built OR.
    run(1, 3'd0, 4'b0000, 1'b0, "or");
    // Bare NOR: every vector wrong. Started from DONE, so results must clear.
    gate_sel = 1;
    run(1, 3'd4, 4'b1111, 1'b0, "nor");
    // AND: vectors 01 and 10 wrong.
    gate_sel = 2;
    run(1, 3'd2, 4'b0110, 1'b0, "and");
    // Restart from a failing DONE with a correct DUT.
    gate_sel = 0;
    run(1, 3'd0, 4'b0000, 1'b0, "swap");

    // SETTLE=3, with a start pulse during WAIT that must be ignored.
    use3 = 1'b1;
    run(3, 3'd0, 4'b0000, 1'b1, "s3");

    // Reset during WAIT of vector 2 after two mismatches.
    use3     = 1'b0;
    gate_sel = 1;
    start1   = 1'b1;
    tick();
    start1   = 1'b0;
    repeat (4) tick();
    check("mid_vec", {6'd0, o_ta, o_tb}, 8'd2);
    check("mid_err", o_err, 8'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("mid_rst");
    gate_sel = 0;
    run(1, 3'd0, 4'b0000, 1'b0, "rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
